// File: rtl/ram_bist_if.sv
// RAM-side bus between the BIST sequencer (master) and the RAM (slave).
interface ram_bist_if #(
  parameter int AW = 6,
  parameter int DW = 8
);
  logic [DW-1:0] ram_data;
  logic [AW-1:0] ram_addr;
  logic          ram_wr;
  logic [DW-1:0] ram_q;

  modport master (
    output ram_data,
    output ram_addr,
    output ram_wr,
    input  ram_q
  );

  modport slave (
    input  ram_data,
    input  ram_addr,
    input  ram_wr,
    output ram_q
  );
endinterface

// File: rtl/ram_bist_seq.sv
// BIST sequencer/checker for a single-port RAM: writes a seeded incrementing
// pattern to every word, reads everything back, counts mismatches and reports
// pass/fail plus the first failing address.
module ram_bist_seq #(
  parameter int AW     = 6,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] seed,
  ram_bist_if.master    ram,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW:0]   err_count,
  output logic [AW-1:0] err_addr
);

  localparam int            DEPTH = 1 << AW;
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
  localparam int            DCW   = 3;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_t;

  state_t        state;
  state_t        state_n;

  logic [AW-1:0] addr_r;
  logic [AW-1:0] addr_n;
  logic [DW-1:0] data_r;
  logic [DW-1:0] data_n;
  logic          wr_r;
  logic          wr_n;
  logic          busy_n;
  logic          done_n;
  logic          pass_n;
  logic [AW:0]   err_n;
  logic [AW-1:0] eaddr_n;
  logic [DW-1:0] seed_q;
  logic [DW-1:0] seed_n;
  logic [DCW-1:0] dcnt;
  logic [DCW-1:0] dcnt_n;

  // Read-issue tracking: one entry per read address, aligned with ram_q at the tap.
  logic          rd_vld_p  [RD_LAT];
  logic [AW-1:0] rd_addr_p [RD_LAT];
  logic          miss;

  // Expected pattern word; the sum wraps modulo 2**DW by construction.
  function automatic logic [DW-1:0] exp_word(input logic [DW-1:0] s,
                                             input logic [AW-1:0] a);
    return s + DW'(a);
  endfunction

  assign ram.ram_data = data_r;
  assign ram.ram_addr = addr_r;
  assign ram.ram_wr   = wr_r;

  // Compare the read data at the tap against the pattern for its address.
  always_comb begin
    miss = rd_vld_p[RD_LAT-1] &&
           (ram.ram_q != exp_word(seed_q, rd_addr_p[RD_LAT-1]));
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n = state;
    addr_n  = addr_r;
    data_n  = data_r;
    wr_n    = 1'b0;
    busy_n  = busy;
    done_n  = 1'b0;
    pass_n  = pass;
    seed_n  = seed_q;
    dcnt_n  = dcnt;
    err_n   = err_count + {{AW{1'b0}}, miss};
    eaddr_n = (miss && (err_count == '0)) ? rd_addr_p[RD_LAT-1] : err_addr;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = WRITE;
          seed_n  = seed;
          addr_n  = '0;
          data_n  = seed;
          wr_n    = 1'b1;
          busy_n  = 1'b1;
          pass_n  = 1'b0;
          err_n   = '0;
          eaddr_n = '0;
        end
      end
      WRITE: begin
        if (addr_r == LAST) begin
          state_n = READ;
          addr_n  = '0;
        end else begin
          addr_n  = addr_r + 1'b1;
          data_n  = exp_word(seed_q, addr_r + 1'b1);
          wr_n    = 1'b1;
        end
      end
      READ: begin
        if (addr_r == LAST) begin
          state_n = DRAIN;
          dcnt_n  = '0;
        end else begin
          addr_n  = addr_r + 1'b1;
        end
      end
      DRAIN: begin
        // The final read result reaches the tap on the last drain cycle, so
        // the pass decision must include this cycle's compare.
        if (dcnt == DCW'(RD_LAT - 1)) begin
          state_n = DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          pass_n  = (err_n == '0);
        end else begin
          dcnt_n  = dcnt + 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Registered RAM drive, status outputs and read-issue valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r    <= '0;
      data_r    <= '0;
      wr_r      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      err_addr  <= '0;
      dcnt      <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        rd_vld_p[i] <= 1'b0;
      end
    end else begin
      addr_r    <= addr_n;
      data_r    <= data_n;
      wr_r      <= wr_n;
      busy      <= busy_n;
      done      <= done_n;
      pass      <= pass_n;
      err_count <= err_n;
      err_addr  <= eaddr_n;
      dcnt      <= dcnt_n;
      rd_vld_p[0] <= (state == READ);
      for (int i = 1; i < RD_LAT; i++) begin
        rd_vld_p[i] <= rd_vld_p[i-1];
      end
    end
  end

  // Latched seed and read-address pipeline; pure data, no reset needed.
  always_ff @(posedge clk) begin
    seed_q       <= seed_n;
    rd_addr_p[0] <= addr_r;
    for (int i = 1; i < RD_LAT; i++) begin
      rd_addr_p[i] <= rd_addr_p[i-1];
    end
  end

endmodule

// File: tb/tb_ram_bist_seq.sv
// Bench for ram_bist_seq: two instances (RD_LAT 1 and 3) each driving a
// behavioural RAM with runtime-selectable read latency and stuck-at faults.
`timescale 1ns/1ps
module tb_ram_bist_seq;
  localparam int AW = 6;
  localparam int DW = 8;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start1, start3;
  logic [7:0] seed1, seed3;
  logic       busy1, done1, pass1, busy3, done3, pass3;
  logic [6:0] err1, err3;
  logic [5:0] ea1, ea3;

  ram_bist_if #(.AW(AW), .DW(DW)) rif1 ();
  ram_bist_if #(.AW(AW), .DW(DW)) rif3 ();

  ram_bist_seq #(.AW(AW), .DW(DW), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .seed(seed1), .ram(rif1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .err_addr(ea1));

  ram_bist_seq #(.AW(AW), .DW(DW), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .seed(seed3), .ram(rif3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .err_addr(ea3));

  // Behavioural RAMs: stuck-at masks apply on read; q appears lat cycles after addr.
  logic [7:0] mem1 [DEPTH];
  logic [7:0] mem3 [DEPTH];
  logic [7:0] st0  [DEPTH];
  logic [7:0] st1  [DEPTH];
  logic [7:0] qp1  [4];
  logic [7:0] qp3  [4];
  int lat1 = 1;
  int lat3 = 3;

  always @(posedge clk) begin
    if (rif1.ram_wr) mem1[rif1.ram_addr] <= rif1.ram_data;
    qp1[0] <= (mem1[rif1.ram_addr] & ~st0[rif1.ram_addr]) | st1[rif1.ram_addr];
    for (int i = 1; i < 4; i++) qp1[i] <= qp1[i-1];
  end
  assign rif1.ram_q = qp1[lat1-1];

  always @(posedge clk) begin
    if (rif3.ram_wr) mem3[rif3.ram_addr] <= rif3.ram_data;
    qp3[0] <= (mem3[rif3.ram_addr] & ~st0[rif3.ram_addr]) | st1[rif3.ram_addr];
    for (int i = 1; i < 4; i++) qp3[i] <= qp3[i-1];
  end
  assign rif3.ram_q = qp3[lat3-1];

  // View of whichever instance is under test.
  int sel = 1;
  logic       m_busy, m_done, m_pass, m_wr;
  logic [6:0] m_err;
  logic [5:0] m_ea, m_addr;
  logic [7:0] m_data;
  always_comb begin
    if (sel == 3) begin
      m_busy = busy3; m_done = done3; m_pass = pass3; m_err = err3; m_ea = ea3;
      m_wr = rif3.ram_wr; m_addr = rif3.ram_addr; m_data = rif3.ram_data;
    end else begin
      m_busy = busy1; m_done = done1; m_pass = pass1; m_err = err1; m_ea = ea1;
      m_wr = rif1.ram_wr; m_addr = rif1.ram_addr; m_data = rif1.ram_data;
    end
  end

  int total = 0;
  int bad   = 0;
  logic [7:0] wseen [DEPTH];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_faults();
    for (int a = 0; a < DEPTH; a++) begin
      st0[a] = 8'h00;
      st1[a] = 8'h00;
    end
  endtask

  task automatic add_fault(input int a, input logic [7:0] mask, input bit one);
    if (one) st1[a] = st1[a] | mask;
    else     st0[a] = st0[a] | mask;
  endtask

  // Reference: stored word per address is the pattern with faults applied;
  // count words that differ and remember the lowest failing address.
  task automatic ref_result(input logic [7:0] s, output int n, output int first);
    n = 0;
    first = 0;
    for (int a = 0; a < DEPTH; a++) begin
      int e;
      logic [7:0] ev, got;
      e   = (int'(s) + a) % 256;
      ev  = 8'(e);
      got = (ev & ~st0[a]) | st1[a];
      if (got != ev) begin
        if (n == 0) first = a;
        n++;
      end
    end
  endtask

  task automatic pulse_start(input logic [7:0] s);
    if (sel == 3) begin seed3 = s; start3 = 1'b1; end
    else          begin seed1 = s; start1 = 1'b1; end
    @(posedge clk); #1;
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  // One complete test with bus monitoring and result checks.
  task automatic run_check(input string nm, input int dsel, input logic [7:0] s,
                           input bit ep, input int ee, input int eea, input int ecyc);
    int cyc, wcnt, wbad;
    bit seen;
    logic hp;
    logic [6:0] he;
    logic [5:0] ha;
    sel = dsel;
    pulse_start(s);
    chk({nm, " busy_after_start"}, m_busy, 1);
    chk({nm, " cleared_result"}, {m_pass, m_err}, 0);
    cyc = 1; wcnt = 0; wbad = 0; seen = 0;
    for (int k = 0; k < 400; k++) begin
      if (m_wr) begin
        wcnt++;
        wseen[m_addr] = m_data;
        if (m_data !== 8'((int'(s) + int'(m_addr)) % 256)) wbad++;
      end
      if (m_done) begin seen = 1; break; end
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, " done_seen"}, seen, 1);
    chk({nm, " done_cycle"}, cyc, ecyc);
    chk({nm, " busy_in_done"}, m_busy, 0);
    chk({nm, " pass"}, m_pass, ep);
    chk({nm, " err_count"}, m_err, ee);
    chk({nm, " err_addr"}, m_ea, eea);
    chk({nm, " write_count"}, wcnt, DEPTH);
    chk({nm, " write_data_bad"}, wbad, 0);
    hp = m_pass; he = m_err; ha = m_ea;
    @(posedge clk); #1;
    chk({nm, " done_one_cycle"}, m_done, 0);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, " result_stable"}, {m_pass, m_err, m_ea}, {hp, he, ha});
  endtask

  typedef struct {
    int         dsel;
    logic [7:0] seed;
    int         lat_ram;
    int         fa0;
    int         fa1;
    logic [7:0] fmask;
    bit         fone;
    bit         ep;
    int         ee;
    int         eea;
    int         ecyc;
  } vec_t;

  vec_t tbl [8];

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, first, cyc, dcount;
    bit seen;
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0; seed1 = 8'h00; seed3 = 8'h00;
    for (int a = 0; a < DEPTH; a++) begin mem1[a] = 8'h00; mem3[a] = 8'h00; end
    for (int i = 0; i < 4; i++) begin qp1[i] = 8'h00; qp3[i] = 8'h00; end
    clear_faults();

    // Reset state of both instances.
    repeat (2) @(posedge clk);
    #1;
    chk("reset dut1 outs", {rif1.ram_data, rif1.ram_addr, rif1.ram_wr, busy1, done1, pass1, err1, ea1}, 0);
    chk("reset dut3 outs", {rif3.ram_data, rif3.ram_addr, rif3.ram_wr, busy3, done3, pass3, err3, ea3}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // dsel seed lat fa0 fa1 mask one | pass err eaddr cycle
    tbl[0] = '{1, 8'h00, 1, -1, -1, 8'h00, 1'b1, 1'b1, 0, 0, 130};
    tbl[1] = '{1, 8'hF0, 1, -1, -1, 8'h00, 1'b1, 1'b1, 0, 0, 130};
    // addr 40 already has bit 3 set under seed 0, so only addr 5 can fail
    tbl[2] = '{1, 8'h00, 1,  5, 40, 8'h08, 1'b1, 1'b0, 1, 5, 130};
    tbl[3] = '{1, 8'h00, 1,  5, 20, 8'h08, 1'b1, 1'b0, 2, 5, 130};
    tbl[4] = '{3, 8'h00, 3, -1, -1, 8'h00, 1'b1, 1'b1, 0, 0, 132};
    tbl[5] = '{1, 8'h00, 3, -1, -1, 8'h00, 1'b1, 1'b0, 64, 0, 130};
    tbl[6] = '{3, 8'h5A, 3, 63, -1, 8'h01, 1'b0, 1'b0, 1, 63, 132};
    tbl[7] = '{1, 8'h7F, 1,  0, -1, 8'h80, 1'b1, 1'b0, 1, 0, 130};

    for (int i = 0; i < 8; i++) begin
      clear_faults();
      if (tbl[i].fa0 >= 0) add_fault(tbl[i].fa0, tbl[i].fmask, tbl[i].fone);
      if (tbl[i].fa1 >= 0) add_fault(tbl[i].fa1, tbl[i].fmask, tbl[i].fone);
      if (tbl[i].dsel == 3) lat3 = tbl[i].lat_ram;
      else                  lat1 = tbl[i].lat_ram;
      run_check($sformatf("vec%0d", i), tbl[i].dsel, tbl[i].seed,
                tbl[i].ep, tbl[i].ee, tbl[i].eea, tbl[i].ecyc);
      if (i == 1) begin
        chk("wrap addr0F", wseen[15], 8'hFF);
        chk("wrap addr10", wseen[16], 8'h00);
      end
      lat1 = 1;
      lat3 = 3;
    end

    // start held high through busy and DONE: one run, one done pulse.
    sel = 1;
    clear_faults();
    seed1 = 8'h33; start1 = 1'b1;
    @(posedge clk); #1;
    dcount = 0; seen = 0;
    for (int k = 0; k < 400; k++) begin
      if (done1) begin dcount++; seen = 1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (done1 || busy1) dcount++;
      @(posedge clk); #1;
    end
    chk("held start done_seen", seen, 1);
    chk("held start single_done", dcount, 1);
    chk("held start pass", pass1, 1);

    // Re-pulsed start during busy and during DONE, with a fault at addr 10.
    clear_faults();
    add_fault(10, 8'h02, 1'b1);
    pulse_start(8'h33);
    cyc = 1; dcount = 0;
    for (int k = 0; k < 160; k++) begin
      if (done1) dcount++;
      start1 = (cyc == 20 || cyc == 70 || cyc == 130);
      @(posedge clk); #1;
      cyc++;
    end
    start1 = 1'b0;
    chk("repulse single_done", dcount, 1);
    chk("repulse idle", busy1, 0);
    chk("repulse err_count", err1, 1);
    chk("repulse err_addr", ea1, 10);
    chk("repulse pass", pass1, 0);
    clear_faults();
    run_check("fresh after fail", 1, 8'h33, 1'b1, 0, 0, 130);

    // Reset in the middle of the read phase aborts the test.
    sel = 1;
    pulse_start(8'h21);
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      if (busy1 && !rif1.ram_wr && rif1.ram_addr == 6'd20) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    chk("abort reached read20", seen, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort outs", {rif1.ram_wr, rif1.ram_addr, busy1, done1, pass1, err1, ea1}, 0);
    dcount = 0;
    for (int k = 0; k < 150; k++) begin
      if (done1 || busy1) dcount++;
      @(posedge clk); #1;
    end
    chk("abort no_done", dcount, 0);
    run_check("after abort", 1, 8'h21, 1'b1, 0, 0, 130);

    // Randomised seeds and fault sets against the reference model.
    for (int r = 0; r < 8; r++) begin
      int ds, nf;
      logic [7:0] s;
      ds = ($urandom_range(0, 1) == 1) ? 3 : 1;
      s  = 8'($urandom);
      clear_faults();
      nf = $urandom_range(0, 3);
      for (int f = 0; f < nf; f++)
        add_fault($urandom_range(0, 63), 8'(1 << $urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      ref_result(s, n, first);
      run_check($sformatf("rand%0d", r), ds, s, (n == 0), n, first, 2 * DEPTH + ds + 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
